// File: rtl/tds_cal_pkg.sv
// Shared types and constants for the TDS latency-alignment calibration controller.
package tds_cal_pkg;

    localparam int NLINK  = 4;
    localparam int DEPTH  = 5;
    localparam int BCID_W = 12;

    localparam logic [2:0] CENTRE_TAP = 3'd2;

    // Search order: centre tap first, then progressively further from it.
    localparam logic [2:0] TAP_PRIO [DEPTH] = '{3'd2, 3'd1, 3'd3, 3'd0, 3'd4};

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED,
        FAIL
    } cal_state_t;

endpackage

// File: rtl/tds_align_calib_ctrl_if.sv
// Control/status bundle between the calibration controller and its surroundings.
interface tds_align_calib_ctrl_if;
    import tds_cal_pkg::*;

    logic                          start;
    logic [1:0]                    ref_sel_in;
    logic                          frame_valid;
    logic [BCID_W-1:0]             ref_bcid;
    logic [NLINK*DEPTH*BCID_W-1:0] tap_bcid;
    logic [1:0]                    ref_sel;
    logic [NLINK*3-1:0]            offset_sel;
    logic [NLINK-1:0]              locked;
    logic                          busy;
    logic                          done;
    logic                          error;

    modport master (
        output start, ref_sel_in, frame_valid, ref_bcid, tap_bcid,
        input  ref_sel, offset_sel, locked, busy, done, error
    );

    modport slave (
        input  start, ref_sel_in, frame_valid, ref_bcid, tap_bcid,
        output ref_sel, offset_sel, locked, busy, done, error
    );

endinterface

// File: rtl/tds_cal_link_tracker.sv
// Per-link tap tracker: priority match against the reference BCID, debounce, lock.
// Loss-of-lock counting exists only when TDS_CAL_MONITOR_EN is defined.
module tds_cal_link_tracker
    import tds_cal_pkg::*;
#(
    parameter int MATCH_CNT = 16
`ifdef TDS_CAL_MONITOR_EN
    ,
    parameter int LOSS_CNT  = 4
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    frame_en,
`ifdef TDS_CAL_MONITOR_EN
    input  logic                    mon_en,
    output logic                    loss,
`endif
    input  logic [BCID_W-1:0]       ref_bcid,
    input  logic [DEPTH*BCID_W-1:0] taps,
    output logic                    locked,
    output logic                    lock_next,
    output logic [2:0]              offset_sel
);

    localparam int CNT_W = $clog2(MATCH_CNT + 1);

    logic             cand_vld;
    logic [2:0]       cand;
    logic [CNT_W-1:0] cnt;

    logic             hit_ok;
    logic [2:0]       hit_tap;
    logic             cand_vld_n;
    logic [2:0]       cand_n;
    logic [CNT_W-1:0] cnt_n;
    logic             lock_now;

    always_comb begin
        hit_ok     = 1'b0;
        hit_tap    = CENTRE_TAP;
        cand_vld_n = cand_vld;
        cand_n     = cand;
        cnt_n      = cnt;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit_ok && (taps[TAP_PRIO[i]*BCID_W +: BCID_W] == ref_bcid)) begin
                hit_ok  = 1'b1;
                hit_tap = TAP_PRIO[i];
            end
        end
        if (!hit_ok) begin
            cand_vld_n = 1'b0;
            cnt_n      = '0;
        end else if (cand_vld && (hit_tap == cand)) begin
            cnt_n = (cnt == CNT_W'(MATCH_CNT)) ? cnt : cnt + 1'b1;
        end else begin
            cand_vld_n = 1'b1;
            cand_n     = hit_tap;
            cnt_n      = CNT_W'(1);
        end
        lock_now = frame_en && !locked && (cnt_n == CNT_W'(MATCH_CNT));
    end

    assign lock_next = locked | lock_now;

    // A locked link is frozen until the next calibration pass clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_vld   <= 1'b0;
            cand       <= CENTRE_TAP;
            cnt        <= '0;
            locked     <= 1'b0;
            offset_sel <= CENTRE_TAP;
        end else if (clear) begin
            cand_vld <= 1'b0;
            cnt      <= '0;
            locked   <= 1'b0;
        end else if (frame_en && !locked) begin
            cand_vld <= cand_vld_n;
            cand     <= cand_n;
            cnt      <= cnt_n;
            if (lock_now) begin
                locked     <= 1'b1;
                offset_sel <= cand_n;
            end
        end
    end

`ifdef TDS_CAL_MONITOR_EN
    localparam int LOSS_W = $clog2(LOSS_CNT + 1);

    logic [LOSS_W-1:0] loss_cnt;
    logic              sel_miss;

    assign sel_miss = (taps[offset_sel*BCID_W +: BCID_W] != ref_bcid);
    assign loss     = mon_en && sel_miss && (loss_cnt == LOSS_W'(LOSS_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (clear) begin
            loss_cnt <= '0;
        end else if (mon_en) begin
            if (!sel_miss) begin
                loss_cnt <= '0;
            end else if (loss_cnt != LOSS_W'(LOSS_CNT)) begin
                loss_cnt <= loss_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/tds_align_calib_ctrl.sv
// TDS link latency-alignment calibration controller: FSM, frame counter, reference select.
// Optional lock monitoring in LOCKED is enabled by defining TDS_CAL_MONITOR_EN.
module tds_align_calib_ctrl
    import tds_cal_pkg::*;
#(
    parameter int MATCH_CNT = 16,
    parameter int TIMEOUT   = 1024
`ifdef TDS_CAL_MONITOR_EN
    ,
    parameter int LOSS_CNT  = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tds_align_calib_ctrl_if.slave  bus
);

    localparam int FC_W = $clog2(TIMEOUT + 1);

    cal_state_t       state;
    logic [FC_W-1:0]  frame_cnt;
    logic [FC_W-1:0]  frame_cnt_inc;
    logic [1:0]       ref_sel;
    logic             busy;
    logic             done;
    logic             error;

    wire [NLINK-1:0]   link_locked;
    wire [NLINK-1:0]   link_lock_next;
    wire [NLINK*3-1:0] link_off;

    logic start_acc;
    logic frame_en;
    logic loss_any;
    logic clear;

    assign start_acc     = bus.start && (state != MEASURE);
    assign frame_en      = bus.frame_valid && (state == MEASURE);
    assign frame_cnt_inc = (frame_cnt == FC_W'(TIMEOUT)) ? frame_cnt : frame_cnt + 1'b1;

`ifdef TDS_CAL_MONITOR_EN
    wire [NLINK-1:0] link_loss;
    logic            mon_en;
    assign mon_en   = bus.frame_valid && (state == LOCKED);
    assign loss_any = |link_loss;
`else
    assign loss_any = 1'b0;
`endif

    assign clear = start_acc || loss_any;

    for (genvar l = 0; l < NLINK; l++) begin : g_link
        tds_cal_link_tracker #(
            .MATCH_CNT (MATCH_CNT)
`ifdef TDS_CAL_MONITOR_EN
            ,
            .LOSS_CNT  (LOSS_CNT)
`endif
        ) u_tracker (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .frame_en   (frame_en),
`ifdef TDS_CAL_MONITOR_EN
            .mon_en     (mon_en),
            .loss       (link_loss[l]),
`endif
            .ref_bcid   (bus.ref_bcid),
            .taps       (bus.tap_bcid[l*DEPTH*BCID_W +: DEPTH*BCID_W]),
            .locked     (link_locked[l]),
            .lock_next  (link_lock_next[l]),
            .offset_sel (link_off[l*3 +: 3])
        );
    end

    // All-locked wins over timeout on the same frame; loss re-entry keeps ref_sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_cnt <= '0;
            ref_sel   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                MEASURE: begin
                    if (bus.frame_valid) begin
                        frame_cnt <= frame_cnt_inc;
                        if (&link_lock_next) begin
                            state <= LOCKED;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (frame_cnt_inc == FC_W'(TIMEOUT)) begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (clear) begin
                        state     <= MEASURE;
                        frame_cnt <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        if (start_acc) begin
                            ref_sel <= bus.ref_sel_in;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ref_sel    = ref_sel;
    assign bus.offset_sel = link_off;
    assign bus.locked     = link_locked;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error;

endmodule

// File: tb/tb_tds_align_calib_ctrl.sv
// Scoreboard bench for tds_align_calib_ctrl: random BCIDs against a frame-level reference model.
// Loss-of-lock expectations follow TDS_CAL_MONITOR_EN.
module tb_tds_align_calib_ctrl;

    localparam int NL   = 4;
    localparam int NT   = 5;
    localparam int BW   = 12;
    localparam int NEED = 16;
    localparam int TOUT = 1024;
    localparam int LOSS = 4;
    localparam int PRIO [NT] = '{2, 1, 3, 0, 4};
    localparam logic [19:0] ALL2 = {4{5'b00100}};

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    tds_align_calib_ctrl_if bus ();

    tds_align_calib_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        string        nm;
        logic [1:0]   rs;
        logic [11:0]  off;
        logic [3:0]   lk;
        logic         busy;
        logic         done;
        logic         err;
    } exp_t;

    exp_t sb [$];

    // Reference model, one step per clock at frame granularity
    bit m_busy, m_done, m_err;
    int m_ref, m_frames;
    int m_cand [NL];
    int m_cnt  [NL];
    bit m_lock [NL];
    int m_off  [NL];
    int m_loss [NL];

    function automatic logic [11:0] tapv(input logic [239:0] taps, input int l, input int t);
        return taps[(l*NT+t)*BW +: BW];
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_ref = 0; m_frames = 0;
        for (int l = 0; l < NL; l++) begin
            m_cand[l] = -1; m_cnt[l] = 0; m_lock[l] = 0; m_off[l] = 2; m_loss[l] = 0;
        end
    endfunction

    function automatic void model_enter();
        m_busy = 1; m_done = 0; m_err = 0; m_frames = 0;
        for (int l = 0; l < NL; l++) begin
            m_cand[l] = -1; m_cnt[l] = 0; m_lock[l] = 0; m_loss[l] = 0;
        end
    endfunction

    function automatic void model_step(input bit st, input int rin, input bit fv,
                                       input logic [11:0] rb, input logic [239:0] taps);
        int  hit;
        bit  all;
        bit  lost;
        if (st && !m_busy) begin
            m_ref = rin;
            model_enter();
            return;
        end
        if (!fv) return;
        if (m_busy) begin
            all = 1;
            for (int l = 0; l < NL; l++) begin
                if (!m_lock[l]) begin
                    hit = -1;
                    for (int p = 0; p < NT; p++)
                        if (hit < 0 && tapv(taps, l, PRIO[p]) == rb) hit = PRIO[p];
                    if (hit < 0) begin
                        m_cand[l] = -1; m_cnt[l] = 0;
                    end else if (hit == m_cand[l]) begin
                        m_cnt[l] = (m_cnt[l] + 1 > NEED) ? NEED : m_cnt[l] + 1;
                    end else begin
                        m_cand[l] = hit; m_cnt[l] = 1;
                    end
                    if (m_cnt[l] == NEED) begin
                        m_lock[l] = 1; m_off[l] = m_cand[l];
                    end
                end
                if (!m_lock[l]) all = 0;
            end
            m_frames = (m_frames + 1 > TOUT) ? TOUT : m_frames + 1;
            if (all) begin
                m_busy = 0; m_done = 1;
            end else if (m_frames == TOUT) begin
                m_busy = 0; m_err = 1;
            end
        end else if (m_done) begin
            lost = 0;
`ifdef TDS_CAL_MONITOR_EN
            for (int l = 0; l < NL; l++) begin
                if (tapv(taps, l, m_off[l]) == rb) m_loss[l] = 0;
                else m_loss[l] = m_loss[l] + 1;
                if (m_loss[l] == LOSS) lost = 1;
            end
`endif
            if (lost) model_enter();
        end
    endfunction

    function automatic void push_exp(input int tag, input string nm);
        exp_t e;
        e.cyc  = tag;
        e.nm   = nm;
        e.rs   = m_ref[1:0];
        e.busy = m_busy;
        e.done = m_done;
        e.err  = m_err;
        for (int l = 0; l < NL; l++) begin
            e.off[l*3 +: 3] = m_off[l][2:0];
            e.lk[l]         = m_lock[l];
        end
        sb.push_back(e);
    endfunction

    task automatic applyStimulus(input bit st, input logic [1:0] rin, input bit fv,
                                 input logic [19:0] masks, input string nm);
        logic [11:0]  rb;
        logic [239:0] taps;
        @(posedge clk);
        #1;
        rb = 12'($urandom);
        for (int l = 0; l < NL; l++)
            for (int t = 0; t < NT; t++)
                taps[(l*NT+t)*BW +: BW] = masks[l*NT+t] ? rb : (rb ^ 12'($urandom_range(1, 4095)));
        bus.start       = st;
        bus.ref_sel_in  = rin;
        bus.frame_valid = fv;
        bus.ref_bcid    = rb;
        bus.tap_bcid    = taps;
        model_step(st, int'(rin), fv, rb, taps);
        push_exp(cyc + 1, nm);
    endtask

    task automatic doReset(input string nm);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.frame_valid = 1'b0;
        model_reset();
        push_exp(cyc + 1, {nm, "_assert"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(cyc, {nm, "_release"});
    endtask

    task automatic checkOutput(input exp_t e);
        n_checks++;
        if (bus.ref_sel !== e.rs || bus.offset_sel !== e.off || bus.locked !== e.lk ||
            bus.busy !== e.busy || bus.done !== e.done || bus.error !== e.err) begin
            n_errors++;
            $display("[TB] FAIL %s cyc=%0d got ref_sel=%0d off=%h locked=%b busy=%b done=%b error=%b want ref_sel=%0d off=%h locked=%b busy=%b done=%b error=%b",
                     e.nm, e.cyc, bus.ref_sel, bus.offset_sel, bus.locked, bus.busy, bus.done,
                     bus.error, e.rs, e.off, e.lk, e.busy, e.done, e.err);
        end
    endtask

    // Monitor: compares each expectation once its clock edge has passed
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [19:0] m;
        int          f;
        cyc = 0;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.ref_sel_in = 2'd0;
        bus.frame_valid = 1'b0;
        bus.ref_bcid = '0;
        bus.tap_bcid = '0;
        model_reset();
        doReset("por");

        // 1: everything aligned at the centre tap, extra matches elsewhere
        applyStimulus(1, 2'd1, 0, ALL2, "t1_start");
        f = 0;
        while (f < NEED + 2) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(0, 2'd0, 0, ALL2, "t1_idle");
            m = ALL2 | 20'($urandom);
            applyStimulus(0, 2'd0, 1, m, "t1_frame");
            f++;
        end

        // 2: link0 only at tap3, link3 only at tap0
        applyStimulus(1, 2'd1, 0, ALL2, "t2_start");
        for (int i = 0; i < NEED + 2; i++) begin
            m = ALL2 | 20'($urandom);
            m[4:0]   = 5'b01000;
            m[19:15] = 5'b00001;
            applyStimulus(0, 2'd2, 1, m, "t2_frame");
        end

        // 3: link2 alternates tap1/tap3 until timeout; starts in MEASURE ignored
        applyStimulus(1, 2'd1, 0, ALL2, "t3_start");
        f = 0;
        while (f < TOUT + 2) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(0, 2'd3, 0, ALL2, "t3_idle");
            m = ALL2;
            m[14:10] = f[0] ? 5'b01000 : 5'b00010;
            applyStimulus((f == 100 || f == 500 || f == 900), 2'd3, 1, m, "t3_frame");
            f++;
        end

        // 4: reset at frame 8 of a measurement
        applyStimulus(1, 2'd3, 0, ALL2, "t4_start");
        for (int i = 0; i < 8; i++) applyStimulus(0, 2'd0, 1, ALL2, "t4_frame");
        doReset("t4_reset");

        // 5/6: lock, then selected tap of link1 misses (3, hit, 4)
        applyStimulus(1, 2'd2, 0, ALL2, "t5_start");
        for (int i = 0; i < NEED; i++) applyStimulus(0, 2'd0, 1, ALL2, "t5_lock");
        m = ALL2;
        m[9:5] = 5'b00010;
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'd0, 1, m, "t5_miss3");
        applyStimulus(0, 2'd0, 1, ALL2, "t5_hit");
        for (int i = 0; i < 4; i++) applyStimulus(0, 2'd0, 1, m, "t5_miss4");
        for (int i = 0; i < NEED + 2; i++) applyStimulus(0, 2'd0, 1, ALL2, "t5_relock");

        // Random rounds: fixed random masks with occasional dropouts
        for (int r = 0; r < 4; r++) begin
            logic [1:0]  rl;
            logic [19:0] base;
            doReset("rnd_reset");
            rl   = 2'($urandom);
            base = 20'($urandom);
            base[rl*5 +: 5] = base[rl*5 +: 5] | 5'b00100;
            applyStimulus(1, rl, 0, base, "rnd_start");
            for (int i = 0; i < 80; i++) begin
                m = base;
                for (int l = 0; l < NL; l++)
                    if (l != int'(rl) && $urandom_range(0, 15) == 0) m[l*5 +: 5] = 5'b00000;
                applyStimulus(0, 2'($urandom), ($urandom_range(0, 3) != 0), m, "rnd_frame");
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
